// File: rtl/conv33_pkg.sv
// Shared types and sizing helpers for the 3x3 streaming window generator.
package conv33_pkg;

  localparam int unsigned CONV33_DATA_WIDTH = 8;

  typedef logic signed [CONV33_DATA_WIDTH-1:0] pix_t;

  // Bit width needed to hold a coordinate in 0..n-1, never less than 1.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv33_line_buf.sv
// One-row line buffer: combinational read, synchronous write, shared address.
module conv33_line_buf
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV33_DATA_WIDTH,
  parameter int unsigned DEPTH      = 28,
  parameter int unsigned AW         = coord_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                addr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  output logic signed [DATA_WIDTH-1:0] rdata_c
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  // Contents are not reset; rows 0/1 of every frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv33_window.sv
// Streaming 3x3 window generator (valid-only, raster input, 1-cycle latency).
// Optional CONV33_WIN_STRIDE2_EN: emit only windows at even row/column.
module conv33_window
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV33_DATA_WIDTH,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_clr,
  input  logic                         pix_valid,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  output logic signed [DATA_WIDTH-1:0] win_0_0,
  output logic signed [DATA_WIDTH-1:0] win_0_1,
  output logic signed [DATA_WIDTH-1:0] win_0_2,
  output logic signed [DATA_WIDTH-1:0] win_1_0,
  output logic signed [DATA_WIDTH-1:0] win_1_1,
  output logic signed [DATA_WIDTH-1:0] win_1_2,
  output logic signed [DATA_WIDTH-1:0] win_2_0,
  output logic signed [DATA_WIDTH-1:0] win_2_1,
  output logic signed [DATA_WIDTH-1:0] win_2_2,
  output logic                         win_valid,
  output logic                         frame_done
);

  localparam int unsigned CW = coord_w(IMG_W);
  localparam int unsigned RW = coord_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic signed [DATA_WIDTH-1:0] top_c, mid_c;
  logic accept_c, col_last_c, row_last_c, win_hit_c;

  // frame_clr wins over a pixel presented in the same cycle.
  assign accept_c   = pix_valid & ~frame_clr;
  assign col_last_c = (col_cnt == COL_LAST);
  assign row_last_c = (row_cnt == ROW_LAST);

`ifdef CONV33_WIN_STRIDE2_EN
  assign win_hit_c = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2)) && !row_cnt[0] && !col_cnt[0];
`else
  assign win_hit_c = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
`endif

  // lb0 holds row r-1, lb1 holds row r-2; lb1 takes lb0's old value (read-before-write).
  conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk    (clk),
    .we     (accept_c),
    .addr   (col_cnt),
    .wdata  (pix_data),
    .rdata_c(mid_c)
  );

  conv33_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk    (clk),
    .we     (accept_c),
    .addr   (col_cnt),
    .wdata  (mid_c),
    .rdata_c(top_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_0_0 <= '0; win_0_1 <= '0; win_0_2 <= '0;
      win_1_0 <= '0; win_1_1 <= '0; win_1_2 <= '0;
      win_2_0 <= '0; win_2_1 <= '0; win_2_2 <= '0;
    end else if (frame_clr) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      // Shift columns left; new right column comes from the line buffers and the pixel.
      win_0_0 <= win_0_1; win_0_1 <= win_0_2; win_0_2 <= top_c;
      win_1_0 <= win_1_1; win_1_1 <= win_1_2; win_1_2 <= mid_c;
      win_2_0 <= win_2_1; win_2_1 <= win_2_2; win_2_2 <= pix_data;
      win_valid  <= win_hit_c;
      frame_done <= col_last_c & row_last_c;
      if (col_last_c) begin
        col_cnt <= '0;
        row_cnt <= row_last_c ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv33_window.sv
// Scoreboard bench for conv33_window on a 5x4 image with pixel = base + r*5 + c + 1.
// Honours CONV33_WIN_STRIDE2_EN when defined for the build.
module tb_conv33_window;
  import conv33_pkg::*;

  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 4;
`ifdef CONV33_WIN_STRIDE2_EN
  localparam int EXP_WINS = ((IMG_H - 1) / 2) * ((IMG_W - 1) / 2);
`else
  localparam int EXP_WINS = (IMG_H - 2) * (IMG_W - 2);
`endif

  typedef struct {
    logic        vld;
    logic        done;
    logic        chk;
    logic [71:0] win;
  } exp_t;

  logic clk = 1'b0;
  logic rst, frame_clr, pix_valid;
  pix_t pix_data;
  pix_t w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic win_valid, frame_done;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int mr = 0, mc = 0;
  int obs_win = 0, obs_done = 0;
  logic        hold_ok = 1'b0;
  logic [71:0] hold_win = '0;

  always #5 clk = ~clk;

  conv33_window #(.DATA_WIDTH(CONV33_DATA_WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .frame_clr(frame_clr), .pix_valid(pix_valid), .pix_data(pix_data),
    .win_0_0(w00), .win_0_1(w01), .win_0_2(w02),
    .win_1_0(w10), .win_1_1(w11), .win_1_2(w12),
    .win_2_0(w20), .win_2_1(w21), .win_2_2(w22),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] exp_win(input int base, input int r, input int c);
    logic [71:0] w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w = (w << 8) | 72'(8'(base + (r - 2 + rr) * int'(IMG_W) + (c - 2 + cc) + 1));
    return w;
  endfunction

  function automatic logic win_hit(input int r, input int c);
`ifdef CONV33_WIN_STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  // One clock of stimulus: predict, push, clock, pop and compare.
  task automatic step(input bit v, input bit clr, input bit r, input int base);
    exp_t e;
    e = '{vld: 1'b0, done: 1'b0, chk: 1'b0, win: '0};
    rst       = r;
    frame_clr = clr;
    pix_valid = v;
    pix_data  = 8'(base + mr * int'(IMG_W) + mc + 1);
    if (r) begin
      mr = 0; mc = 0; hold_ok = 1'b0;
      e.chk = 1'b1;
    end else if (clr) begin
      mr = 0; mc = 0;
    end else if (v) begin
      e.vld  = win_hit(mr, mc);
      e.done = (mr == int'(IMG_H) - 1) && (mc == int'(IMG_W) - 1);
      if (e.vld) begin
        e.win = exp_win(base, mr, mc); e.chk = 1'b1;
        hold_win = e.win; hold_ok = 1'b1;
      end else begin
        hold_ok = 1'b0;
      end
      if (mc == int'(IMG_W) - 1) begin
        mc = 0;
        mr = (mr == int'(IMG_H) - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end else if (hold_ok) begin
      e.chk = 1'b1; e.win = hold_win;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("win_valid", 72'(win_valid), 72'(e.vld));
    chk("frame_done", 72'(frame_done), 72'(e.done));
    if (e.chk)
      chk(r ? "reset_win" : "window", {w00, w01, w02, w10, w11, w12, w20, w21, w22}, e.win);
    if (win_valid === 1'b1) obs_win++;
    if (frame_done === 1'b1) obs_done++;
  endtask

  task automatic frame(input string tag, input int base, input bit gaps);
    int w0, d0;
    w0 = obs_win; d0 = obs_done;
    for (int i = 0; i < int'(IMG_W * IMG_H); i++) begin
      step(1'b1, 1'b0, 1'b0, base);
      if (gaps) step(1'b0, 1'b0, 1'b0, base);
    end
    chk({tag, "_win_count"}, 72'(obs_win - w0), 72'(EXP_WINS));
    chk({tag, "_done_count"}, 72'(obs_done - d0), 72'(1));
  endtask

  task automatic partial(input int npix, input int base);
    int w0;
    w0 = obs_win;
    for (int i = 0; i < npix; i++) step(1'b1, 1'b0, 1'b0, base);
    chk("partial_no_win", 72'(obs_win - w0), 72'(0));
  endtask

  initial begin
    rst = 1'b1; frame_clr = 1'b0; pix_valid = 1'b0; pix_data = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    frame("cont", 0, 1'b0);
    frame("toggle", 0, 1'b1);
    frame("b2b_a", 0, 1'b0);
    frame("b2b_b", 100, 1'b0);

    // Abort mid-frame with reset after pixel 12.
    partial(12, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    frame("after_rst", 0, 1'b0);

    // frame_clr together with pixel 9 drops it and restarts the frame.
    partial(8, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    chk("clr_no_win", 72'(win_valid), 72'(0));
    frame("after_clr", 0, 1'b0);

    repeat (2) step(1'b0, 1'b0, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
